// File: rtl/nfifo2_rr.sv
// Multi-flow FIFO: FLOWS queues of BLOCK_SIZE words in one memory, flow-tagged output, optional round-robin read.
// Latency: accepted read -> data_vld after 1 cycle (OUTPUT_REG=0) or 2 cycles (OUTPUT_REG=1).
// Backpressure: per-flow full drops writes; pipe_en=0 freezes the output pipe and blocks reads. Optional AFULL: NFIFO2_AFULL_EN.
module nfifo2_rr #(
    parameter int DATA_WIDTH   = 64,
    parameter int FLOWS        = 4,
    parameter int BLOCK_SIZE   = 16,
    parameter int OUTPUT_REG   = 1,
    parameter int RR_MODE      = 0,
    parameter int AFULL_THRESH = 12,
    localparam int FW = $clog2(FLOWS),
    localparam int CW = $clog2(BLOCK_SIZE) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [FW-1:0]         wr_blk_addr,
    input  logic                  write,
    output logic [FLOWS-1:0]      full,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_vld,
    output logic [FW-1:0]         rd_flow,
    input  logic [FW-1:0]         rd_blk_addr,
    input  logic                  read,
    input  logic                  pipe_en,
    output logic [FLOWS-1:0]      empty,
`ifdef NFIFO2_AFULL_EN
    output logic [FLOWS-1:0]      afull,
`endif
    output logic [FLOWS*CW-1:0]   status
);

    localparam int PW = CW - 1;
    localparam int AW = FW + PW;

    logic [DATA_WIDTH-1:0] mem [FLOWS*BLOCK_SIZE];

    logic [FLOWS*PW-1:0] wr_ptr_flat;
    logic [FLOWS*PW-1:0] rd_ptr_flat;
    logic [FLOWS*CW-1:0] cnt_flat;
    logic [FLOWS-1:0]    full_v;
    logic [FLOWS-1:0]    empty_v;

    logic [FW-1:0] last_grant;
    logic [FW-1:0] rr_sel;
    logic [FW-1:0] rr_cand;
    logic          rr_hit;
    logic [FW-1:0] sel;
    logic          wr_acc;
    logic          rd_acc;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    // First non-empty flow strictly after last_grant, wrapping back to last_grant itself.
    always_comb begin
        rr_sel  = last_grant;
        rr_cand = '0;
        rr_hit  = 1'b0;
        for (int i = 1; i <= FLOWS; i++) begin
            rr_cand = last_grant + FW'(i);
            if (!rr_hit && !empty_v[rr_cand]) begin
                rr_sel = rr_cand;
                rr_hit = 1'b1;
            end
        end
    end

    assign sel     = (RR_MODE != 0) ? rr_sel : rd_blk_addr;
    assign wr_acc  = write && !full_v[wr_blk_addr];
    assign rd_acc  = read && pipe_en && !empty_v[sel];
    assign wr_addr = {wr_blk_addr, wr_ptr_flat[wr_blk_addr*PW +: PW]};
    assign rd_addr = {sel, rd_ptr_flat[sel*PW +: PW]};

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_addr] <= data_in;
        end
    end

    for (genvar g = 0; g < FLOWS; g++) begin : g_flow
        logic          wr_f;
        logic          rd_f;
        logic [PW-1:0] wptr;
        logic [PW-1:0] rptr;
        logic [CW-1:0] cnt;

        assign wr_f = wr_acc && (wr_blk_addr == FW'(g));
        assign rd_f = rd_acc && (sel == FW'(g));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
            end else begin
                if (wr_f) begin
                    wptr <= wptr + 1'b1;
                end
                if (rd_f) begin
                    rptr <= rptr + 1'b1;
                end
                cnt <= cnt + {{(CW-1){1'b0}}, wr_f} - {{(CW-1){1'b0}}, rd_f};
            end
        end

        assign wr_ptr_flat[g*PW +: PW] = wptr;
        assign rd_ptr_flat[g*PW +: PW] = rptr;
        assign cnt_flat[g*CW +: CW]    = cnt;
        assign full_v[g]               = (cnt == CW'(BLOCK_SIZE));
        assign empty_v[g]              = (cnt == '0);
`ifdef NFIFO2_AFULL_EN
        assign afull[g]                = (cnt >= CW'(AFULL_THRESH));
`endif
    end

    assign full   = full_v;
    assign empty  = empty_v;
    assign status = cnt_flat;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= FW'(FLOWS - 1);
        end else if ((RR_MODE != 0) && rd_acc) begin
            last_grant <= sel;
        end
    end

    // Stage 1: synchronous memory read, captured only while the pipe advances.
    logic                  s1_vld;
    logic [DATA_WIDTH-1:0] s1_dat;
    logic [FW-1:0]         s1_flow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vld  <= 1'b0;
            s1_dat  <= '0;
            s1_flow <= '0;
        end else if (pipe_en) begin
            s1_vld <= rd_acc;
            if (rd_acc) begin
                s1_dat  <= mem[rd_addr];
                s1_flow <= sel;
            end
        end
    end

    if (OUTPUT_REG != 0) begin : g_oreg
        logic                  s2_vld;
        logic [DATA_WIDTH-1:0] s2_dat;
        logic [FW-1:0]         s2_flow;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s2_vld  <= 1'b0;
                s2_dat  <= '0;
                s2_flow <= '0;
            end else if (pipe_en) begin
                s2_vld  <= s1_vld;
                s2_dat  <= s1_dat;
                s2_flow <= s1_flow;
            end
        end

        assign data_vld = s2_vld;
        assign data_out = s2_dat;
        assign rd_flow  = s2_flow;
    end else begin : g_noreg
        assign data_vld = s1_vld;
        assign data_out = s1_dat;
        assign rd_flow  = s1_flow;
    end

endmodule

// File: tb/tb_nfifo2_rr.sv
// Bench for nfifo2_rr: one RR_MODE=0 and one RR_MODE=1 instance share clock, writes and pipe_en;
// a queue model predicts every delivered word, plus vector table and hand sequences for corner cases.
module tb_nfifo2_rr;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        write = 1'b0;
    logic [1:0]  wa = '0;
    logic [63:0] din = '0;
    logic        rd0 = 1'b0;
    logic        rd1 = 1'b0;
    logic [1:0]  rba = '0;
    logic        pe = 1'b1;

    logic [3:0]  full0, full1, empty0, empty1;
    logic [19:0] st0, st1;
    logic        dv0, dv1;
    logic [1:0]  df0, df1;
    logic [63:0] dd0, dd1;
`ifdef NFIFO2_AFULL_EN
    logic [3:0]  af0, af1;
`endif

    always #5 clk = ~clk;

    nfifo2_rr #(.DATA_WIDTH(64), .FLOWS(4), .BLOCK_SIZE(16), .OUTPUT_REG(1), .RR_MODE(0), .AFULL_THRESH(12)) dut0 (
        .clk(clk), .reset(reset), .data_in(din), .wr_blk_addr(wa), .write(write), .full(full0),
        .data_out(dd0), .data_vld(dv0), .rd_flow(df0), .rd_blk_addr(rba), .read(rd0), .pipe_en(pe),
        .empty(empty0),
`ifdef NFIFO2_AFULL_EN
        .afull(af0),
`endif
        .status(st0));

    nfifo2_rr #(.DATA_WIDTH(64), .FLOWS(4), .BLOCK_SIZE(16), .OUTPUT_REG(1), .RR_MODE(1), .AFULL_THRESH(12)) dut1 (
        .clk(clk), .reset(reset), .data_in(din), .wr_blk_addr(wa), .write(write), .full(full1),
        .data_out(dd1), .data_vld(dv1), .rd_flow(df1), .rd_blk_addr(rba), .read(rd1), .pipe_en(pe),
        .empty(empty1),
`ifdef NFIFO2_AFULL_EN
        .afull(af1),
`endif
        .status(st1));

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: per-dut per-flow word queues and a scoreboard of expected {flow,data} outputs.
    logic [63:0] fq [8][$];
    logic [65:0] sb [2][$];
    logic [1:0]  mlast;
    logic        pe_edge = 1'b0;
    logic [1:0]  m_sel;
    logic        m_racc, m_wacc, m_found;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) fq[i].delete();
            sb[0].delete();
            sb[1].delete();
            mlast   = 2'd3;
            pe_edge = 1'b0;
        end else begin
            pe_edge = pe;
            for (int d = 0; d < 2; d++) begin
                m_wacc = write && (fq[d*4 + int'(wa)].size() < 16);
                if (d == 0) begin
                    m_sel  = rba;
                    m_racc = rd0 && pe && (fq[int'(m_sel)].size() != 0);
                end else begin
                    m_sel   = mlast;
                    m_found = 1'b0;
                    for (int i = 1; i <= 4; i++) begin
                        if (!m_found && fq[4 + ((int'(mlast) + i) % 4)].size() != 0) begin
                            m_sel   = 2'((int'(mlast) + i) % 4);
                            m_found = 1'b1;
                        end
                    end
                    m_racc = rd1 && pe && m_found;
                end
                if (m_racc) begin
                    sb[d].push_back({m_sel, fq[d*4 + int'(m_sel)].pop_front()});
                    if (d == 1) mlast = m_sel;
                end
                if (m_wacc) fq[d*4 + int'(wa)].push_back(din);
            end
        end
    end

    logic [66:0] cur_m;
    logic [66:0] prev_m [2];
    logic [65:0] exp_m;

    always @(posedge clk) begin
        #2;
        for (int d = 0; d < 2; d++) begin
            cur_m = (d == 0) ? {dv0, df0, dd0} : {dv1, df1, dd1};
            if (reset) begin
                if (pe_edge) begin
                    if (cur_m[66]) begin
                        if (sb[d].size() == 0) begin
                            check($sformatf("sb_underflow_dut%0d", d), 1, 0);
                        end else begin
                            exp_m = sb[d].pop_front();
                            check($sformatf("sb_word_dut%0d", d), cur_m[65:0], exp_m);
                        end
                    end
                end else begin
                    check($sformatf("stall_hold_dut%0d", d), cur_m, prev_m[d]);
                end
            end
            prev_m[d] = cur_m;
        end
    end

    typedef struct {
        logic        wr;
        logic [1:0]  wa;
        logic [63:0] din;
        logic        rd;
        logic [1:0]  ra;
        logic        pe;
        logic [3:0]  exp_empty;
        logic [19:0] exp_status;
    } vec_t;

    vec_t        vt [10];
    logic [1:0]  got [$];
    logic [1:0]  rr_exp [6];
    int          ndel;
    logic        seen;

    task automatic idle();
        write = 1'b0;
        rd0   = 1'b0;
        rd1   = 1'b0;
        pe    = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic wr_word(input logic [1:0] f, input logic [63:0] d);
        write = 1'b1;
        wa    = f;
        din   = d;
        tick();
        write = 1'b0;
    endtask

    initial begin
        vt[0] = '{1'b1, 2'd1, 64'hA1, 1'b0, 2'd0, 1'b1, 4'b1101, 20'h00020};
        vt[1] = '{1'b1, 2'd3, 64'hB3, 1'b0, 2'd0, 1'b1, 4'b0101, 20'h08020};
        vt[2] = '{1'b1, 2'd1, 64'hA2, 1'b0, 2'd0, 1'b1, 4'b0101, 20'h08040};
        vt[3] = '{1'b0, 2'd0, 64'h0,  1'b1, 2'd1, 1'b1, 4'b0101, 20'h08020};
        vt[4] = '{1'b1, 2'd0, 64'hC0, 1'b1, 2'd3, 1'b1, 4'b1100, 20'h00021};
        vt[5] = '{1'b0, 2'd0, 64'h0,  1'b1, 2'd2, 1'b1, 4'b1100, 20'h00021};
        vt[6] = '{1'b1, 2'd1, 64'hD1, 1'b1, 2'd1, 1'b1, 4'b1100, 20'h00021};
        vt[7] = '{1'b0, 2'd0, 64'h0,  1'b1, 2'd1, 1'b0, 4'b1100, 20'h00021};
        vt[8] = '{1'b0, 2'd0, 64'h0,  1'b1, 2'd0, 1'b1, 4'b1101, 20'h00020};
        vt[9] = '{1'b0, 2'd0, 64'h0,  1'b1, 2'd1, 1'b1, 4'b1111, 20'h00000};
        rr_exp = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};

        // Reset state
        #1;
        check("rst_empty", empty0, 4'hF);
        check("rst_full", full0, 4'h0);
        check("rst_status", st0, 20'h0);
        check("rst_out", {dv0, df0, dd0}, 67'h0);
        tick();
        reset = 1'b1;
        tick();

        // Vector table on the RR_MODE=0 instance
        for (int i = 0; i < 10; i++) begin
            write = vt[i].wr;
            wa    = vt[i].wa;
            din   = vt[i].din;
            rd0   = vt[i].rd;
            rba   = vt[i].ra;
            pe    = vt[i].pe;
            tick();
            check($sformatf("vec%0d_empty", i), empty0, vt[i].exp_empty);
            check($sformatf("vec%0d_status", i), st0, vt[i].exp_status);
        end
        idle();
        repeat (4) tick();

        // Read latency with the output register
        do_reset();
        wr_word(2'd1, 64'hA1);
        rd0 = 1'b1;
        rba = 2'd1;
        tick();
        rd0 = 1'b0;
        check("lat_n1_vld", dv0, 1'b0);
        tick();
        check("lat_n2_vld", dv0, 1'b1);
        check("lat_n2_data", dd0, 64'hA1);
        check("lat_n2_flow", df0, 2'd1);
        tick();
        check("lat_n3_vld", dv0, 1'b0);

        // Fill flow 2 to full and overrun
        do_reset();
        for (int k = 0; k < 17; k++) begin
            write = 1'b1;
            wa    = 2'd2;
            din   = 64'h200 + 64'(k);
            tick();
`ifdef NFIFO2_AFULL_EN
            if (k == 10) check("afull_below", af0[2], 1'b0);
            if (k == 11) check("afull_at", af0[2], 1'b1);
`endif
            if (k == 15) check("full_at16", full0, 4'b0100);
        end
        write = 1'b0;
        check("full_after17", full0, 4'b0100);
        check("status_after17", st0, 20'h04000);
        rd0 = 1'b1;
        rba = 2'd2;
        repeat (18) tick();
        rd0 = 1'b0;
        repeat (3) tick();
        check("drain2_empty", empty0, 4'hF);

        // Round-robin on the RR_MODE=1 instance
        do_reset();
        wr_word(2'd0, 64'h1000);
        wr_word(2'd0, 64'h1001);
        wr_word(2'd2, 64'h1020);
        wr_word(2'd2, 64'h1021);
        wr_word(2'd3, 64'h1030);
        wr_word(2'd3, 64'h1031);
        got.delete();
        rd1 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (dv1) got.push_back(df1);
        end
        check("rr_count", got.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < got.size()) check($sformatf("rr_seq%0d", i), got[i], rr_exp[i]);
        end
        check("rr_vld_end", dv1, 1'b0);
        check("rr_empty_end", empty1, 4'hF);
        rd1 = 1'b0;

        // Stream from flow 3 with a 3-cycle stall
        do_reset();
        for (int k = 0; k < 8; k++) wr_word(2'd3, 64'h300 + 64'(k));
        ndel = 0;
        rd0  = 1'b1;
        rba  = 2'd3;
        for (int c = 0; c < 20; c++) begin
            pe = !(c >= 3 && c < 6);
            tick();
            if (pe && dv0) ndel++;
        end
        pe  = 1'b1;
        rd0 = 1'b0;
        check("stall_delivered", ndel, 8);
        check("stall_empty", empty0[3], 1'b1);

        // Simultaneous write+read on flow 0 across pointer wrap
        do_reset();
        wr_word(2'd0, 64'h600);
        for (int k = 1; k <= 40; k++) begin
            write = 1'b1;
            wa    = 2'd0;
            din   = 64'h600 + 64'(k);
            rd0   = 1'b1;
            rba   = 2'd0;
            tick();
            check($sformatf("wr_rd_status%0d", k), st0, 20'h00001);
        end
        write = 1'b0;
        tick();
        rd0 = 1'b0;
        repeat (3) tick();
        check("wr_rd_empty", empty0, 4'hF);

        // Asynchronous reset in the middle of traffic
        do_reset();
        wr_word(2'd0, 64'h700);
        wr_word(2'd0, 64'h701);
        wr_word(2'd1, 64'h710);
        rd0 = 1'b1;
        rba = 2'd0;
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_empty", empty0, 4'hF);
        check("mid_rst_full", full0, 4'h0);
        check("mid_rst_vld", dv0, 1'b0);
        check("mid_rst_status", st0, 20'h0);
        rd0 = 1'b0;
        tick();
        reset = 1'b1;
        rd0   = 1'b1;
        rba   = 2'd0;
        seen  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (dv0) seen = 1'b1;
        end
        rd0 = 1'b0;
        check("post_rst_no_stale", seen, 1'b0);

        repeat (4) tick();
        check("sb0_drained", sb[0].size(), 0);
        check("sb1_drained", sb[1].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
